// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared constants and helpers for the iomem GPIO block
// Purpose: register offsets (decoded from iomem_addr[5:2]), the maximum
//          pin-vector width and the byte-strobe expansion helper.
// Ports:   none (package).
package gpio_pkg;

  localparam int GPIO_MAX_W = 32;

  localparam logic [3:0] OFS_OUT     = 4'd0;
  localparam logic [3:0] OFS_OUT_SET = 4'd1;
  localparam logic [3:0] OFS_OUT_CLR = 4'd2;
  localparam logic [3:0] OFS_OUT_TGL = 4'd3;
  localparam logic [3:0] OFS_IN      = 4'd4;
  localparam logic [3:0] OFS_RISE    = 4'd5;
  localparam logic [3:0] OFS_FALL    = 4'd6;
  localparam logic [3:0] OFS_IRQ_EN  = 4'd7;
  localparam logic [3:0] OFS_RAW     = 4'd8;

  // Expand the four byte strobes into a 32-bit bit mask.
  function automatic logic [GPIO_MAX_W-1:0] byte_mask(input logic [3:0] wstrb);
    return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - per-pin 2-flop synchroniser plus optional debounce filter
// Purpose: brings one asynchronous pin into the clk domain and produces the
//          debounced level. Build option GPIO_DEBOUNCE_EN enables the
//          DEB_CYCLES stability filter; without it the debounced level is
//          the synchronised level delayed by one register.
// Ports:   clk, reset (async, active-high), pin_in (async pin),
//          raw_out (synchronised level), deb_out (debounced level).
module gpio_debounce #(
  parameter int DEB_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_in,
  output logic raw_out,
  output logic deb_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic deb_q, deb_d;

  always_comb begin
    meta_d = pin_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      deb_q  <= deb_d;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised level disagrees with the
  // debounced one; any agreement (a bounce back) restarts it from zero.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unused_deb_cycles = DEB_CYCLES;

  always_comb begin
    deb_d = sync_q;
  end
`endif

  assign raw_out = sync_q;
  assign deb_out = deb_q;

endmodule

// File: rtl/iomem_gpio.sv
// rtl/iomem_gpio.sv - memory-mapped GPIO with debounced inputs and edge interrupts
// Purpose: iomem slave exposing OUT/SET/CLR/TGL output registers, debounced
//          and raw input views, sticky RISE/FALL edge flags and an IRQ enable.
//          Build option GPIO_DEBOUNCE_EN selects the debounce filter in
//          gpio_debounce.
// Ports:   clk, reset (async, active-high);
//          iomem_valid/iomem_ready handshake, iomem_wstrb (0 = read),
//          iomem_addr ([5:2] decoded), iomem_wdata, iomem_rdata;
//          gpio_in (async pins), gpio_out (output register), irq (level).
module iomem_gpio
  import gpio_pkg::*;
#(
  parameter int N_IN       = 8,
  parameter int N_OUT      = 16,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [N_IN-1:0]  gpio_in,
  output logic [N_OUT-1:0] gpio_out,
  output logic             irq
);

  logic [N_OUT-1:0] out_q, out_d;
  logic [N_IN-1:0]  rise_q, rise_d;
  logic [N_IN-1:0]  fall_q, fall_d;
  logic [N_IN-1:0]  irq_en_q, irq_en_d;
  logic [N_IN-1:0]  in_dly_q, in_dly_d;
  logic             ready_q, ready_d;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [N_IN-1:0]  raw;
  logic [N_IN-1:0]  in_now;
  logic [N_IN-1:0]  rise_set, fall_set, rise_clr, fall_clr;
  logic             ack, wr;
  logic [3:0]       ofs;
  logic [31:0]      wmask, wbits, rd;
  logic             unused_bits;

  assign unused_bits = ^{iomem_addr[31:6], iomem_addr[1:0], wmask, wbits};

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    gpio_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .pin_in (gpio_in[i]),
      .raw_out(raw[i]),
      .deb_out(in_now[i])
    );
  end

  always_comb begin
    // An ack is only issued when ready is low, so a held valid is
    // acknowledged on alternate cycles.
    ack   = iomem_valid && !ready_q;
    wr    = ack && (iomem_wstrb != 4'b0000);
    ofs   = iomem_addr[5:2];
    wmask = byte_mask(iomem_wstrb);
    wbits = iomem_wdata & wmask;

    rise_set = in_now & ~in_dly_q;
    fall_set = ~in_now & in_dly_q;
    rise_clr = (wr && ofs == OFS_RISE) ? wbits[N_IN-1:0] : '0;
    fall_clr = (wr && ofs == OFS_FALL) ? wbits[N_IN-1:0] : '0;

    // Set is OR-ed after the clear so a coinciding edge survives the W1C.
    rise_d   = (rise_q & ~rise_clr) | rise_set;
    fall_d   = (fall_q & ~fall_clr) | fall_set;
    out_d    = out_q;
    irq_en_d = irq_en_q;
    in_dly_d = in_now;

    if (wr) begin
      case (ofs)
        OFS_OUT:     out_d = (out_q & ~wmask[N_OUT-1:0]) | wbits[N_OUT-1:0];
        OFS_OUT_SET: out_d = out_q | wbits[N_OUT-1:0];
        OFS_OUT_CLR: out_d = out_q & ~wbits[N_OUT-1:0];
        OFS_OUT_TGL: out_d = out_q ^ wbits[N_OUT-1:0];
        OFS_IRQ_EN:  irq_en_d = (irq_en_q & ~wmask[N_IN-1:0]) | wbits[N_IN-1:0];
        default:     ;
      endcase
    end

    case (ofs)
      OFS_OUT:    rd = 32'(out_q);
      OFS_IN:     rd = 32'(in_now);
      OFS_RISE:   rd = 32'(rise_q);
      OFS_FALL:   rd = 32'(fall_q);
      OFS_IRQ_EN: rd = 32'(irq_en_q);
      OFS_RAW:    rd = 32'(raw);
      default:    rd = '0;
    endcase

    ready_d = ack;
    rdata_d = ack ? rd : '0;
    irq_d   = |((rise_q | fall_q) & irq_en_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      irq_en_q <= '0;
      in_dly_q <= '0;
      ready_q  <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      out_q    <= out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_en_q <= irq_en_d;
      in_dly_q <= in_dly_d;
      ready_q  <= ready_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign gpio_out    = out_q;
  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq         = irq_q;

endmodule

// File: doc/iomem_gpio.md
IOMEM_GPIO -- requirements
Module: iomem_gpio

Interface
REQ-001 SHALL have parameter N_IN, default 8: number of input pins, 1..32.
REQ-002 SHALL have parameter N_OUT, default 16: number of output pins, 1..32.
REQ-003 SHALL have parameter DEB_CYCLES, default 1000000: debounce stability window in clk cycles, at least 1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port iomem_valid, input, 1 bit: request, already qualified by the parent's address decode.
REQ-007 SHALL have port iomem_ready, output, 1 bit: one-cycle acknowledge.
REQ-008 SHALL have port iomem_wstrb, input, 4 bits: byte write enables; all zero means a read.
REQ-009 SHALL have port iomem_addr, input, 32 bits: only bits [5:2] are decoded.
REQ-010 SHALL have port iomem_wdata, input, 32 bits: write data.
REQ-011 SHALL have port iomem_rdata, output, 32 bits: read data.
REQ-012 SHALL have port gpio_in, input, N_IN bits: asynchronous pins such as buttons.
REQ-013 SHALL have port gpio_out, output, N_OUT bits: output register, e.g. to LEDs.
REQ-014 SHALL have port irq, output, 1 bit: level interrupt, registered.

Function
REQ-015 Register map by addr[5:2] SHALL be: 0 OUT (RW); 1 OUT_SET (W1S, reads 0); 2 OUT_CLR (W1C, reads 0); 3 OUT_TGL (write-1-toggle, reads 0); 4 IN (RO, debounced); 5 RISE (sticky, W1C); 6 FALL (sticky, W1C); 7 IRQ_EN (RW); 8 RAW (RO, synchronised, not debounced).
REQ-016 Unmapped offsets 9..15 SHALL read 0, ignore writes, and still be acknowledged.
REQ-017 Bits at or above N_IN / N_OUT SHALL read 0 and SHALL ignore writes.
REQ-018 Writes SHALL honour iomem_wstrb per byte for every writable register, including W1S/W1C/TGL.
REQ-019 Handshake: iomem_ready SHALL assert exactly one cycle after iomem_valid is sampled high while iomem_ready is low.
REQ-020 iomem_ready SHALL stay high for exactly one cycle.
REQ-021 No back-to-back ack: with valid held, acks SHALL occur every second cycle.
REQ-022 Write side effects SHALL take effect on the same edge that raises iomem_ready.
REQ-023 iomem_rdata SHALL be valid while iomem_ready is high and SHALL be 0 otherwise.
REQ-024 Read value SHALL be register state before any same-cycle update.
REQ-025 gpio_in SHALL pass through a 2-flop synchroniser per bit.
REQ-026 Rising edge of a debounced bit SHALL set RISE[i]; falling edge SHALL set FALL[i], one cycle after the IN change.
REQ-027 If an edge set and a W1C of the same bit coincide, set SHALL win.
REQ-028 irq SHALL equal the registered OR of ((RISE|FALL) & IRQ_EN), one cycle after the flag change.
REQ-029 OUT_SET, OUT_CLR and OUT_TGL SHALL update gpio_out in the same cycle as their write.

Reset
REQ-030 While reset is high, the following SHALL be 0: gpio_out, iomem_ready, iomem_rdata, irq, IRQ_EN, RISE, FALL, IN, synchronisers, debounce counters.
REQ-031 Reset asserted mid-transaction SHALL abort it with no ack.
REQ-032 After reset, inputs already high SHALL produce RISE once they are debounced.

Configuration
REQ-033 With GPIO_DEBOUNCE_EN defined, each bit's IN SHALL change only after the synchronised input differs from IN for DEB_CYCLES consecutive cycles.
REQ-034 Any bounce under GPIO_DEBOUNCE_EN SHALL restart the bit's counter, which is $clog2(DEB_CYCLES+1) bits wide.
REQ-035 Without GPIO_DEBOUNCE_EN, IN SHALL equal RAW delayed by one register, DEB_CYCLES SHALL be ignored, and no counters SHALL exist.

Structure
REQ-036 Package gpio_pkg SHALL hold the register offset constants (OFS_OUT..OFS_RAW) and the maximum width constant 32.
REQ-037 The synchroniser plus debounce for one bit SHALL be sub-module gpio_debounce, instantiated N_IN times via generate.

Verification (bench: N_IN=5, N_OUT=16, DEB_CYCLES=4)
REQ-038 Write OUT=0x00F0, then SET 0x000F, CLR 0x0030, TGL 0x8000 -> gpio_out 0x80CF; each ack one cycle after valid.
REQ-039 Write OUT=0xFFFF with wstrb=0b0001 from reset -> gpio_out 0x00FF.
REQ-040 gpio_in[2] bounces 1,0,1 in 3-cycle chunks, then stays 1 -> IN[2] rises only after 4 stable cycles; RISE=0x04 exactly once.
REQ-041 IRQ_EN=0x04, RISE[2] set -> irq=1; W1C RISE 0x04 coinciding with a new rising edge on bit 2 -> RISE[2] stays 1 and irq stays 1.
REQ-042 valid held high on a read of offset 12 -> rdata 0, ready pulses on alternate cycles.
REQ-043 Reset asserted while valid is high -> no ack, all outputs 0 asynchronously.
